// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/decode/indirect sequencer.
package fetch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StT0,
        StT1,
        StT2,
        StT3,
        StExec,
        StHalted,
        StErr
    } state_t;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    localparam logic [2:0] OPC_REG_IO = 3'd7;

    function automatic logic [7:0] onehot8(input logic [2:0] op);
        return 8'b1 << op;
    endfunction

endpackage

// File: rtl/fetch_seq_mem_wait_timer.sv
// Loadable down-counter bounding how long a memory read may wait for mem_ready.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic timeout
);

    // Loaded with MEM_TIMEOUT-1 so the last allowed wait cycle sees zero.
    localparam logic [7:0] LOAD_VAL = 8'(MEM_TIMEOUT - 1);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= LOAD_VAL;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    assign timeout = (cnt_q == 8'd0);

endmodule

// File: rtl/fetch_seq.sv
// T-state sequencer for fetch, decode and indirect cycles; hands decoded ops to the execute unit.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic             ir_i,
    input  logic [2:0]       ir_opcode,
    input  logic             mem_ready,
    input  logic             exec_done,
    output logic [2:0]       bus_sel,
    output logic             mem_read,
    output logic             pc_incr,
    output logic             ld_ar,
    output logic             ld_ir,
    output logic             ld_i,
    output logic [7:0]       dec_op,
    output logic             exec_start,
    output logic             running,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t           state_q, state_d;
    logic [2:0]       bus_sel_q, bus_sel_d;
    logic             mem_read_q, mem_read_d;
    logic             ld_ar_q, ld_ar_d;
    logic             ld_i_q, ld_i_d;
    logic [7:0]       dec_op_q, dec_op_d;
    logic             exec_start_q, exec_start_d;
    logic             running_q, running_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_t1, in_t3, timeout;

    assign in_t1 = (state_q == StT1);
    assign in_t3 = (state_q == StT3);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (!(in_t1 || in_t3)),
        .timeout(timeout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StHalted: if (start) state_d = StT0;
            StT0:             state_d = StT1;
            StT1: begin
                if (mem_ready)    state_d = StT2;
                else if (timeout) state_d = StErr;
            end
            StT2: begin
                if (ir_opcode != OPC_REG_IO && ir_i) state_d = StT3;
                else                                 state_d = StExec;
            end
            StT3: begin
                if (mem_ready)    state_d = StExec;
                else if (timeout) state_d = StErr;
            end
            StExec:  if (exec_done) state_d = halt ? StHalted : StT0;
            StErr:   state_d = StErr;
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with it.
    always_comb begin
        bus_sel_d    = BUS_NONE;
        mem_read_d   = 1'b0;
        ld_ar_d      = 1'b0;
        ld_i_d       = 1'b0;
        exec_start_d = 1'b0;
        running_d    = 1'b0;
        err_d        = 1'b0;
        case (state_d)
            StT0: begin
                bus_sel_d = BUS_PC;
                ld_ar_d   = 1'b1;
                running_d = 1'b1;
            end
            StT1, StT3: begin
                bus_sel_d  = BUS_MEM;
                mem_read_d = 1'b1;
                running_d  = 1'b1;
            end
            StT2: begin
                bus_sel_d = BUS_IR;
                ld_ar_d   = 1'b1;
                ld_i_d    = 1'b1;
                running_d = 1'b1;
            end
            StExec: begin
                exec_start_d = (state_q != StExec);
                running_d    = 1'b1;
            end
            StErr:   err_d = 1'b1;
            default: ;
        endcase

        dec_op_d = dec_op_q;
        if (state_q == StT2) dec_op_d = onehot8(ir_opcode);
        if (state_d inside {StIdle, StHalted, StErr}) dec_op_d = '0;

        cnt_d = cnt_q;
        if (state_q == StExec && exec_done) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            bus_sel_q    <= BUS_NONE;
            mem_read_q   <= 1'b0;
            ld_ar_q      <= 1'b0;
            ld_i_q       <= 1'b0;
            dec_op_q     <= '0;
            exec_start_q <= 1'b0;
            running_q    <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            bus_sel_q    <= bus_sel_d;
            mem_read_q   <= mem_read_d;
            ld_ar_q      <= ld_ar_d;
            ld_i_q       <= ld_i_d;
            dec_op_q     <= dec_op_d;
            exec_start_q <= exec_start_d;
            running_q    <= running_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    // Handshake-qualified strobes fire in the mem_ready cycle itself.
    assign pc_incr    = in_t1 && mem_ready;
    assign ld_ir      = in_t1 && mem_ready;
    assign ld_ar      = ld_ar_q || (in_t3 && mem_ready);
    assign bus_sel    = bus_sel_q;
    assign mem_read   = mem_read_q;
    assign ld_i       = ld_i_q;
    assign dec_op     = dec_op_q;
    assign exec_start = exec_start_q;
    assign running    = running_q;
    assign err        = err_q;
    assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Randomized scoreboard bench for fetch_seq: per-instruction timelines queued, monitor compares.
module tb_fetch_seq;

    localparam int unsigned MT = 15;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0, halt = 1'b0, ir_i = 1'b0, mem_ready = 1'b0, exec_done = 1'b0;
    logic [2:0]    ir_opcode = 3'd0;
    logic [2:0]    bus_sel;
    logic          mem_read, pc_incr, ld_ar, ld_ir, ld_i, exec_start, running, err;
    logic [7:0]    dec_op;
    logic [CW-1:0] instr_cnt;

    fetch_seq #(
        .MEM_TIMEOUT(MT),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .halt      (halt),
        .ir_i      (ir_i),
        .ir_opcode (ir_opcode),
        .mem_ready (mem_ready),
        .exec_done (exec_done),
        .bus_sel   (bus_sel),
        .mem_read  (mem_read),
        .pc_incr   (pc_incr),
        .ld_ar     (ld_ar),
        .ld_ir     (ld_ir),
        .ld_i      (ld_i),
        .dec_op    (dec_op),
        .exec_start(exec_start),
        .running   (running),
        .err       (err),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [2:0]    bus;
        logic          mr, pci, ldar, ldir, ldi, xs, run, er;
        logic          chk_dec;
        logic [7:0]    dec;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          exp_q[$];
    int            errors = 0;
    int            checks = 0;
    logic [CW-1:0] model_cnt = '0;
    logic [7:0]    prev_dec = 8'h00;
    bit            halted;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, expv);
        end
    endtask

    function automatic exp_t blank(input int c);
        exp_t e;
        e.cyc = c; e.bus = 3'd0; e.mr = 0; e.pci = 0; e.ldar = 0; e.ldir = 0; e.ldi = 0;
        e.xs = 0; e.run = 0; e.er = 0; e.chk_dec = 1; e.dec = prev_dec; e.cnt = model_cnt;
        return e;
    endfunction

    exp_t m;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            m = exp_q.pop_front();
            if (m.cyc < cyc) begin
                chk("stale_expectation", 32'(cyc), 32'(m.cyc));
            end else begin
                chk($sformatf("bus_sel@%0d", cyc), 32'(bus_sel), 32'(m.bus));
                chk($sformatf("mem_read@%0d", cyc), 32'(mem_read), 32'(m.mr));
                chk($sformatf("pc_incr@%0d", cyc), 32'(pc_incr), 32'(m.pci));
                chk($sformatf("ld_ar@%0d", cyc), 32'(ld_ar), 32'(m.ldar));
                chk($sformatf("ld_ir@%0d", cyc), 32'(ld_ir), 32'(m.ldir));
                chk($sformatf("ld_i@%0d", cyc), 32'(ld_i), 32'(m.ldi));
                chk($sformatf("exec_start@%0d", cyc), 32'(exec_start), 32'(m.xs));
                chk($sformatf("running@%0d", cyc), 32'(running), 32'(m.run));
                chk($sformatf("err@%0d", cyc), 32'(err), 32'(m.er));
                chk($sformatf("instr_cnt@%0d", cyc), 32'(instr_cnt), 32'(m.cnt));
                if (m.chk_dec) chk($sformatf("dec_op@%0d", cyc), 32'(dec_op), 32'(m.dec));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs;
        start = 1'($urandom); halt = 1'($urandom); ir_opcode = 3'($urandom);
        ir_i = 1'($urandom); mem_ready = 1'($urandom); exec_done = 1'($urandom);
    endtask

    // One cycle in IDLE or HALTED: everything inactive, stray handshakes ignored.
    task automatic idle_cycle(input logic s, input logic h);
        exp_t e;
        e = blank(cyc);
        e.dec = 8'h00;
        exp_q.push_back(e);
        randomize_inputs();
        start = s;
        halt = h;
        tick();
    endtask

    // Called in the T0 cycle; w1/w3 are wait cycles before mem_ready, xw before exec_done.
    task automatic run_instr(input int op, input bit ib, input int w1, input int w3,
                             input int xw, input bit hlt, input bit abort);
        int c, t1e, t2, t3e, ex, done, last;
        bit ind;
        logic [7:0] oh;
        exp_t e;
        c = cyc;
        ind = ib && (op != 7);
        oh = 8'b1 << op;
        t1e = c + 1 + w1;
        t2 = t1e + 1;
        t3e = ind ? t2 + 1 + w3 : t2;
        ex = t3e + 1;
        done = ex + xw;
        last = abort ? t2 + 2 : done;
        for (int k = c; k <= last; k++) begin
            e = blank(k);
            e.run = 1;
            if (k > t2) e.dec = oh;
            if (k == c) begin
                e.bus = 3'd2; e.ldar = 1;
            end else if (k <= t1e) begin
                e.bus = 3'd7; e.mr = 1;
                if (k == t1e) begin e.pci = 1; e.ldir = 1; end
            end else if (k == t2) begin
                e.bus = 3'd5; e.ldar = 1; e.ldi = 1;
            end else if (k <= t3e) begin
                e.bus = 3'd7; e.mr = 1;
                if (k == t3e) e.ldar = 1;
            end else begin
                e.xs = (k == ex);
            end
            exp_q.push_back(e);
        end
        for (int k = c; k <= last; k++) begin
            randomize_inputs();
            if (k > c && k <= t1e) begin
                mem_ready = (k == t1e);
                if (hlt) halt = 1'b1;
            end else if (k == t2) begin
                ir_opcode = 3'(op);
                ir_i = ib;
            end else if (k > t2 && k <= t3e) begin
                mem_ready = (k == t3e);
            end else if (k >= ex) begin
                exec_done = (k == done);
                if (k == done) halt = hlt;
            end
            tick();
        end
        if (!abort) begin
            model_cnt = model_cnt + 1'b1;
            prev_dec = hlt ? 8'h00 : oh;
        end
    endtask

    // Called in the T0 cycle; mem_ready never arrives in T1.
    task automatic timeout_run;
        int c;
        exp_t e;
        c = cyc;
        for (int k = c; k <= c + int'(MT) + 6; k++) begin
            e = blank(k);
            if (k == c) begin
                e.bus = 3'd2; e.ldar = 1; e.run = 1;
            end else if (k <= c + int'(MT)) begin
                e.bus = 3'd7; e.mr = 1; e.run = 1;
            end else begin
                e.er = 1; e.chk_dec = 0;
            end
            exp_q.push_back(e);
        end
        for (int k = c; k <= c + int'(MT) + 6; k++) begin
            randomize_inputs();
            if (k > c && k <= c + int'(MT)) mem_ready = 1'b0;
            if (k > c + int'(MT) && k[0]) start = 1'b1;
            tick();
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_bus_sel"}, 32'(bus_sel), 0);
        chk({tag, "_mem_read"}, 32'(mem_read), 0);
        chk({tag, "_strobes"}, 32'({pc_incr, ld_ar, ld_ir, ld_i, exec_start}), 0);
        chk({tag, "_running"}, 32'(running), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_dec_op"}, 32'(dec_op), 0);
        chk({tag, "_instr_cnt"}, 32'(instr_cnt), 0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        idle_cycle(0, 0);
        idle_cycle(1, 0);
        run_instr(3, 0, 0, 0, 1, 0, 0);
        run_instr(2, 1, 4, 4, 2, 0, 0);
        run_instr(7, 1, 0, 0, 0, 0, 0);
        run_instr(1, 1, int'(MT) - 1, int'(MT) - 1, 0, 0, 0);
        run_instr(5, 0, 3, 0, 1, 1, 0);
        idle_cycle(0, 1);
        idle_cycle(1, 1);
        run_instr(6, 0, 0, 0, 0, 1, 0);
        idle_cycle(1, 0);
        halted = 0;
        for (int i = 0; i < 30; i++) begin
            bit h;
            h = ($urandom_range(0, 7) == 0);
            run_instr(int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), h, 0);
            halted = h;
            if (h && i != 29) begin
                repeat ($urandom_range(0, 2)) idle_cycle(0, 1'($urandom));
                idle_cycle(1, 1'($urandom));
                halted = 0;
            end
        end
        if (halted) idle_cycle(1, 0);

        run_instr(4, 1, 0, 5, 0, 0, 1);
        reset = 1'b1;
        #1;
        check_all_zero("reset_in_t3");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_cnt = '0;
        prev_dec = 8'h00;

        idle_cycle(1, 0);
        for (int i = 0; i < 16; i++) begin
            run_instr(int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0, 0);
        end
        chk("cnt_wrap", 32'(instr_cnt), 0);

        timeout_run();
        reset = 1'b1;
        #1;
        check_all_zero("reset_from_err");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_cnt = '0;
        prev_dec = 8'h00;
        idle_cycle(0, 0);
        idle_cycle(0, 0);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
